// File: rtl/hit_count_display.sv
// Hit-count to two-digit decimal converter driving a multiplexed active-low
// seven-segment display. Define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module hit_count_display #(
  parameter int COUNT_W     = 6,
  parameter int REFRESH_DIV = 50000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [COUNT_W-1:0] i_hit_count,
  input  logic               i_hit_valid,
  output logic [1:0]         o_digit_sel,
  output logic [6:0]         o_seven_sig,
  output logic               o_busy,
  output logic               dbg_state
);

  // i_hit_valid is a one-cycle strobe with no back-pressure: every strobe is
  // accepted, either started at once, parked in the one-deep pending slot
  // (latest wins), or loaded directly on the completing edge.

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [COUNT_W-1:0] TEN     = COUNT_W'(10);

  logic [0:0]         state;
  logic [COUNT_W-1:0] work;
  logic [3:0]         tens_acc;
  logic [COUNT_W-1:0] pend_val;
  logic               pend_flag;
  logic [3:0]         disp_tens;
  logic [3:0]         disp_ones;

  logic [CNT_W-1:0]   refresh_cnt;
  logic               slot;
  logic [CNT_W-1:0]   next_cnt;
  logic               next_slot;
  logic [3:0]         active_digit;
  logic [6:0]         seg_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Subtract-by-10 conversion; the display registers move only on completion.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      work      <= '0;
      tens_acc  <= '0;
      pend_val  <= '0;
      pend_flag <= 1'b0;
      disp_tens <= '0;
      disp_ones <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_hit_valid) begin
            work     <= i_hit_count;
            tens_acc <= '0;
            state    <= CONV;
          end
        end
        CONV: begin
          if (work >= TEN) begin
            work     <= work - TEN;
            tens_acc <= tens_acc + 4'd1;
            if (i_hit_valid) begin
              pend_val  <= i_hit_count;
              pend_flag <= 1'b1;
            end
          end else begin
            disp_tens <= tens_acc;
            disp_ones <= work[3:0];
            // A strobe on the completing edge is newer than anything pending.
            if (i_hit_valid) begin
              work      <= i_hit_count;
              tens_acc  <= '0;
              pend_flag <= 1'b0;
            end else if (pend_flag) begin
              work      <= pend_val;
              tens_acc  <= '0;
              pend_flag <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    next_cnt  = refresh_cnt + CNT_W'(1);
    next_slot = slot;
    if (refresh_cnt == CNT_MAX) begin
      next_cnt  = '0;
      next_slot = ~slot;
    end
    active_digit = next_slot ? disp_tens : disp_ones;
    seg_next     = seg7(active_digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (next_slot && (disp_tens == 4'd0)) begin
      seg_next = 7'b1111111;
    end
`else
`endif
  end

  // Segments and digit enables share one register stage so they switch together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      refresh_cnt <= '0;
      slot        <= 1'b0;
      o_digit_sel <= 2'b10;
      o_seven_sig <= 7'b1000000;
    end else begin
      refresh_cnt <= next_cnt;
      slot        <= next_slot;
      o_digit_sel <= next_slot ? 2'b01 : 2'b10;
      o_seven_sig <= seg_next;
    end
  end

  assign o_busy    = (state == CONV);
  assign dbg_state = state;

endmodule

// File: tb/tb_hit_count_display.sv
// Bench for hit_count_display: directed boundary/chaining steps plus random
// strobes, checked every cycle against a cycle-level reference model.
module tb_hit_count_display;

  localparam int DIV = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] hit_count = '0;
  logic       hit_valid = 1'b0;
  logic [1:0] digit_sel;
  logic [6:0] seven_sig;
  logic       busy;
  logic       dbg_state;

  always #5 clk = ~clk;

  hit_count_display #(.COUNT_W(6), .REFRESH_DIV(DIV)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_hit_count (hit_count),
    .i_hit_valid (hit_valid),
    .o_digit_sel (digit_sel),
    .o_seven_sig (seven_sig),
    .o_busy      (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
  int         m_val, m_rem, m_pend_val, m_tens, m_ones, m_cnt;
  logic       m_busy, m_pend, m_slot;
  logic [1:0] exp_sel;
  logic [6:0] exp_seg;
  logic [7:0] exp_q [$];
  int         n_vec = 0;
  int         n_fail = 0;

  function automatic logic [6:0] disp_seg(input logic is_tens, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    if (is_tens && d == 0) return 7'b1111111;
`else
`endif
    return seg_tab[d];
  endfunction

  task automatic model_start(input int v);
    m_val  = v;
    m_rem  = v / 10;
    m_busy = 1'b1;
    m_pend = 1'b0;
  endtask

  task automatic model_edge(input logic v, input int val);
    int old_t, old_o;
    if (!rst_n) begin
      m_busy = 0; m_pend = 0; m_val = 0; m_rem = 0; m_pend_val = 0;
      m_tens = 0; m_ones = 0; m_cnt = 0; m_slot = 0;
      exp_sel = 2'b10; exp_seg = 7'b1000000;
    end else begin
      old_t = m_tens;
      old_o = m_ones;
      if (m_cnt == DIV - 1) begin m_cnt = 0; m_slot = ~m_slot; end
      else m_cnt++;
      exp_sel = m_slot ? 2'b01 : 2'b10;
      exp_seg = disp_seg(m_slot, m_slot ? old_t : old_o);
      if (!m_busy) begin
        if (v) model_start(val);
      end else if (m_rem > 0) begin
        m_rem--;
        if (v) begin m_pend = 1; m_pend_val = val; end
      end else begin
        m_tens = m_val / 10;
        m_ones = m_val % 10;
        if (v) model_start(val);
        else if (m_pend) model_start(m_pend_val);
        else m_busy = 0;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input int val);
    hit_valid = v;
    hit_count = 6'(val);
    @(posedge clk);
    model_edge(v, val);
    #1;
    chk("busy", {7'd0, busy}, {7'd0, m_busy});
    chk("state", {7'd0, dbg_state}, {7'd0, m_busy});
    chk("digit_sel", {6'd0, digit_sel}, {6'd0, exp_sel});
    chk("seven_sig", {1'b0, seven_sig}, {1'b0, exp_seg});
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) step(1'b0, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 30) begin
      step(1'b0, 0);
      n++;
    end
    chk("idle_timeout", {7'd0, busy}, 8'd0);
  endtask

  task automatic conv_timed(input int v, input int exp_n);
    int n = 0;
    step(1'b1, v);
    while (busy === 1'b1 && n < 20) begin
      n++;
      step(1'b0, 0);
    end
    chk("busy_cycles", 8'(n), 8'(exp_n));
  endtask

  // Pops the expected tens/ones pair and watches both slots for two periods.
  task automatic check_display();
    logic [7:0] pair;
    logic [6:0] seen_t, seen_o;
    seen_t = 'x;
    seen_o = 'x;
    pair = exp_q.pop_front();
    repeat (2 * DIV + 1) begin
      step(1'b0, 0);
      if (digit_sel === 2'b10) seen_o = seven_sig;
      if (digit_sel === 2'b01) seen_t = seven_sig;
    end
    chk("disp_ones", {1'b0, seen_o}, {1'b0, disp_seg(1'b0, int'(pair[3:0]))});
    chk("disp_tens", {1'b0, seen_t}, {1'b0, disp_seg(1'b1, int'(pair[7:4]))});
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    do_reset(3);
    repeat (16) step(1'b0, 0);
    exp_q.push_back(8'h00); check_display();

    conv_timed(37, 4);
    exp_q.push_back(8'h37); check_display();

    conv_timed(0, 1);
    exp_q.push_back(8'h00); check_display();
    conv_timed(9, 1);
    exp_q.push_back(8'h09); check_display();
    conv_timed(10, 2);
    exp_q.push_back(8'h10); check_display();
    conv_timed(63, 7);
    exp_q.push_back(8'h63); check_display();

    step(1'b1, 63); step(1'b1, 5); step(1'b1, 12);
    wait_idle();
    exp_q.push_back(8'h12); check_display();

    step(1'b1, 63);
    repeat (6) step(1'b0, 0);
    step(1'b1, 5);
    wait_idle();
    exp_q.push_back(8'h05); check_display();

    step(1'b1, 58); step(1'b0, 0);
    do_reset(1);
    repeat (12) step(1'b0, 0);
    exp_q.push_back(8'h00); check_display();

    conv_timed(7, 1);
    exp_q.push_back(8'h07); check_display();
    conv_timed(40, 5);
    exp_q.push_back(8'h40); check_display();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 63));
      end
    end
    wait_idle();
    repeat (4) step(1'b0, 0);

    hit_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_count_display.md
Name: hit_count_display

Overview:
- Downstream consumer of the detector's hit counter.
- Takes the 6-bit hit count and its valid strobe, converts the value to two decimal digits with a sequential subtract-by-10 FSM, and drives a 2-digit time-multiplexed active-low seven-segment display.
- Sits between the detector core and the board display pins inside the system top level.

Parameters:
- COUNT_W, 6: width of the incoming hit count. Maximum value 63, so the tens digit is at most 6.
- REFRESH_DIV, 50000: clock cycles per digit slot. Must be ≥2. Benches use 4.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_hit_count  input  COUNT_W  hit count from detector; sampled only when i_hit_valid=1.
- i_hit_valid  input  1  single-cycle strobe: i_hit_count is new.
- o_digit_sel  output  2  active-low digit enables. Bit0 = ones digit, bit1 = tens digit.
- o_seven_sig  output  7  active-low segments, order {g,f,e,d,c,b,a}.
- o_busy  output  1  conversion in progress.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - FSM goes to IDLE; pending flag is cleared.
  - Display registers tens=0, ones=0; refresh counter=0.
  - o_digit_sel=2'b10, o_seven_sig=7'b1000000 (digit '0'), o_busy=0.
  - Reset mid-conversion discards both the conversion and any pending value.
- FSM states: IDLE, CONV.
  - IDLE, i_hit_valid=1 at edge E0: work=i_hit_count, tens_acc=0, go to CONV.
  - CONV, work≥10: work-=10, tens_acc+=1, stay in CONV.
  - CONV, work<10: disp_tens=tens_acc, disp_ones=work[3:0]. Then go to CONV on a new or pending value (see below), otherwise IDLE.
- Latency:
  - For value v with k=floor(v/10), the display registers update at edge E0+k+1.
  - o_seven_sig reflects the new value no later than E0+k+2, when that digit's slot is active.
- o_busy is registered: 1 from E0 until the completing edge, then 0 on return to IDLE. It stays 1 if a chained conversion starts.
- i_hit_valid while in CONV: the value is stored in a one-deep pending register and the pending flag is set. A later strobe overwrites it (latest wins).
- Completing edge:
  - If i_hit_valid=1 on that same edge, the new value loads directly into work and the pending flag clears; the newer value wins.
  - Else if the pending flag is set, the pending value loads, the flag clears, and the FSM stays in CONV.
  - Else the FSM goes to IDLE.
- Boundary values:
  - v=0 completes at E0+1 with 0 subtractions.
  - v=63 takes 6 subtractions and completes at E0+7.
  - v=9 → tens 0, ones 9. v=10 → tens 1, ones 0.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap edge the active digit toggles: ones (2'b10) ↔ tens (2'b01).
  - o_digit_sel is never 2'b00 or 2'b11 after reset.
  - The refresh counter runs independently of conversion activity.
- Output register: o_seven_sig=seg(active digit's display register) and o_digit_sel are registered together. They always change on the same edge, so there is no ghosting.
- Segment map (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other code=1111111.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when disp_tens=0, the tens slot drives o_seven_sig=7'b1111111 (blank). o_digit_sel still cycles normally.
- Not defined: tens slot shows '0' (1000000) for values 0..9.

Test Plan:
- Reset and idle, REFRESH_DIV=4: hold i_rst_n=0 for 3 cycles, release, no strobe.
  - Required: o_busy=0, o_seven_sig=1000000 in both slots.
  - Required: o_digit_sel alternates 10/01 every 4 cycles.
- Single conversion: strobe i_hit_count=37.
  - Required: o_busy=1 for 4 cycles.
  - Required: ones slot shows 1111000 (7), tens slot shows 0110000 (3).
- Boundaries: strobe 0, then 9, 10, 63, each after o_busy falls.
  - Required: 0 completes in 1 cycle; 63 completes in 7 cycles.
  - Required displayed pairs: 0/0, 0/9, 1/0, 6/3.
- Strobes during busy:
  - 63, then 5 and 12 on consecutive cycles while busy → 12 is converted after 63 and 5 is dropped; final display 1/2.
  - 63, then 5 on the exact completing edge → 5 is converted next; final display 0/5.
- Reset mid-conversion: strobe 58, assert i_rst_n=0 two cycles later.
  - Required: o_busy=0 and display 0/0; no later update from 58.
- With LEADING_ZERO_BLANK_EN defined: strobe 7.
  - Required: tens slot drives 1111111, ones slot 1111000.
  - Required: strobe 40 → tens slot 0011001.
